cpu_byte_mem_bridge: RTL and testbench
======================================

# cpu_byte_mem_bridge

Memory-side bus bridge sitting directly downstream of the `spcpu` core's data port. Accepts one 8-bit or 16-bit read/write request at a time from the CPU side and sequences it onto a byte-wide synchronous RAM with 1-cycle read latency. 16-bit accesses are split into two byte accesses, big-endian (high byte at `addr`), matching the hi/lo register-pair ordering. The bidirectional `data_inout` tristate remains in the integrating level; this block uses split read/write buses.

## Interface
Parameters:
- `ADDR_W`, 16, address width (CPU and memory side).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  CPU request strobe; sampled only in IDLE.
- `req_addr`  in  ADDR_W  byte address of access.
- `req_acc_sz`  in  1  1 = 16-bit (`cpu_data_acc_sz_16`), 0 = 8-bit.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wdata`  in  16  write data; 8-bit writes use `[7:0]`.
- `rdata`  out  16  read result; 8-bit reads zero-extended.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever state != IDLE.
- `mem_en`  out  1  byte RAM access enable.
- `mem_we`  out  1  byte RAM write enable (qualified by `mem_en`).
- `mem_addr`  out  ADDR_W  byte RAM address.
- `mem_wdata`  out  8  byte RAM write data.
- `mem_rdata`  in  8  byte RAM read data, valid the cycle after `mem_en && !mem_we`.

## Operation
- States: IDLE, ACC0, ACC1, CAP, DONE.
- IDLE: on `req`=1, latch addr/acc_sz/we/wdata, go to ACC0. `req`=0: stay.
- ACC0: `mem_en`=1, `mem_addr`=latched addr, `mem_we`=latched we. `mem_wdata` = `wdata[15:8]` if 16-bit, `wdata[7:0]` if 8-bit. Next: 16-bit → ACC1; 8-bit read → CAP; 8-bit write → DONE.
- ACC1: `mem_en`=1, `mem_addr`=addr+1 (mod 2^ADDR_W, so 0xFFFF wraps to 0x0000), `mem_wdata`=`wdata[7:0]`. Read: capture `mem_rdata` into `rdata[15:8]`. Next: read → CAP; write → DONE.
- CAP: `mem_en`=0. Capture `mem_rdata` into `rdata[7:0]`; for 8-bit reads also clear `rdata[15:8]`. Next: DONE.
- DONE: `ready`=1, `mem_en`=0. Next: IDLE.
- `mem_en`, `mem_we`, `mem_addr`, and `mem_wdata` are registered (state-decoded from registers, no combinational path from `req`*).
- `mem_we`=0 whenever `mem_en`=0.
- `rdata` holds its value until the next read's capture. Writes never modify `rdata`.
- `req` in any state other than IDLE is ignored, including DONE. The CPU re-asserts after `ready`.

## Timing
- Reset (async, `reset`=0): state IDLE. All outputs 0: `rdata`=0, `ready`=0, `busy`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Latched request registers are cleared.
- Reset mid-transaction aborts immediately. No completion pulse. A partially written 16-bit word is left as-is (high byte only).
- Latency, counted from the edge sampling `req` (cycle 0) to the cycle in which `ready`=1:
  - 8-bit write: 2.
  - 8-bit read: 3.
  - 16-bit write: 3.
  - 16-bit read: 4.
- Earliest next request: `req` sampled the cycle after DONE (IDLE). Back-to-back throughput for a 16-bit read is one access per 5 cycles.
- `busy` rises the cycle after `req` is sampled and falls the cycle after DONE.

## Test plan
- Reset: hold `reset`=0 mid 16-bit read (in ACC1) → all outputs 0 asynchronously. Release, `req` 8-bit read @0x0010 with RAM[0x10]=0xA5 → `ready` at cycle 3, `rdata`=0x00A5.
- 16-bit write 0xBEEF @0x0100 → ACC0 `mem_addr`=0x0100 `mem_wdata`=0xBE, ACC1 `mem_addr`=0x0101 `mem_wdata`=0xEF, `ready` at cycle 3. A subsequent 16-bit read @0x0100 → `rdata`=0xBEEF at cycle 4.
- Wrap: 16-bit read @0xFFFF with RAM[0xFFFF]=0x12, RAM[0x0000]=0x34 → second `mem_addr`=0x0000, `rdata`=0x1234.
- 8-bit write `req_wdata`=0x7733 @0x0200 → single `mem_en` cycle, `mem_wdata`=0x33, RAM[0x0201] untouched, `rdata` unchanged, `ready` at cycle 2.
- Busy rejection: `req` held high continuously with changing addresses during a 16-bit read → only the first address is accessed. A new transaction starts only when `req` is sampled in IDLE. `busy`=1 through DONE.
- Zero-extension: 16-bit read returning 0xFFFF, then 8-bit read of 0x80 → `rdata`=0x0080.

Source files
------------

// File: rtl/cpu_byte_mem_bridge.sv
// cpu_byte_mem_bridge
// Sequences one 8-bit or 16-bit CPU data access onto a byte-wide synchronous
// RAM with 1-cycle read latency. 16-bit accesses are big-endian: the high byte
// lives at addr and the low byte at addr+1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for req; the only state in which req is sampled
// ST_ACC0  | first byte access at addr (the only access for 8-bit)
// ST_ACC1  | second byte access at addr+1; read data of ACC0 -> rdata[15:8]
// ST_CAP   | no access; last read byte -> rdata[7:0]
// ST_DONE  | one-cycle ready pulse, then back to idle
//
// All bus-side outputs are registers loaded from the next-state decode, so
// they line up with the state they belong to and have no combinational path
// from the request inputs.

module cpu_byte_mem_bridge #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_acc_sz,
    input  logic              req_we,
    input  logic [15:0]       req_wdata,
    output logic [15:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
        ST_ACC1 = 3'd2,
        ST_CAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sz_q, sz_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              mem_en_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    logic              ready_d;
    logic              busy_d;

    // Next-state, request latch and decode of the registered bus outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sz_d        = sz_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACC0;
                    addr_d  = req_addr;
                    sz_d    = req_acc_sz;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                end
            end
            ST_ACC0: begin
                if (sz_q)      state_d = ST_ACC1;
                else if (we_q) state_d = ST_DONE;
                else           state_d = ST_CAP;
            end
            ST_ACC1: state_d = we_q ? ST_DONE : ST_CAP;
            ST_CAP:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the state being entered, using the freshly latched
        // request so ACC0 already carries the new address on its first cycle.
        ready_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        case (state_d)
            ST_ACC0: begin
                mem_en_d    = 1'b1;
                mem_we_d    = we_d;
                mem_addr_d  = addr_d;
                mem_wdata_d = sz_d ? wdata_d[15:8] : wdata_d[7:0];
            end
            ST_ACC1: begin
                mem_en_d    = 1'b1;
                mem_we_d    = we_d;
                mem_addr_d  = addr_d + ADDR_W'(1);
                mem_wdata_d = wdata_d[7:0];
            end
            default: begin
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    // State, latched request and registered bus-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            sz_q      <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sz_q      <= sz_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            ready     <= ready_d;
            busy      <= busy_d;
        end
    end

    // Read capture: a byte read in one state arrives on mem_rdata in the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 16'h0000;
        end else begin
            if (state_q == ST_ACC1 && !we_q) begin
                rdata[15:8] <= mem_rdata;
            end
            if (state_q == ST_CAP) begin
                rdata[7:0] <= mem_rdata;
                if (!sz_q) begin
                    rdata[15:8] <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_byte_mem_bridge.sv
// Bench for cpu_byte_mem_bridge: byte RAM model, transaction-level reference
// model, per-cycle output compare, directed scenarios and a random phase.

module tb_cpu_byte_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] req_addr;
    logic        req_acc_sz;
    logic        req_we;
    logic [15:0] req_wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    cpu_byte_mem_bridge #(.ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_acc_sz (req_acc_sz),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .rdata      (rdata),
        .ready      (ready),
        .busy       (busy),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_byte(input logic [15:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // Byte RAM: access seen during a cycle, read data presented in the next
    // cycle; otherwise mem_rdata carries junk so mistimed captures show up.
    logic [7:0] pend;
    logic       pend_v;
    initial begin
        mem_rdata = 8'h00;
        pend_v    = 1'b0;
        pend      = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else begin
                    pend   = ram[mem_addr];
                    pend_v = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            mem_rdata = pend_v ? pend : 8'($urandom);
            pend_v    = 1'b0;
        end
    end

    // Transaction-level reference model: a request taken in idle occupies
    // 2 + size16 + is_read cycles up to ready, then one more to return idle.
    logic        m_active = 1'b0;
    int          m_k = 0;
    int          m_L = 0;
    logic [15:0] m_a = 16'h0;
    logic        m_sz = 1'b0;
    logic        m_we = 1'b0;
    logic [15:0] m_wd = 16'h0;
    logic [15:0] m_exp_rd = 16'h0;
    logic [15:0] m_rd = 16'h0;

    always @(posedge clk) begin
        logic [15:0] a1;
        if (!reset) begin
            m_active = 1'b0;
            m_rd     = 16'h0;
        end else if (m_active) begin
            if (m_k == m_L) begin
                m_active = 1'b0;
                if (!m_we) m_rd = m_exp_rd;
            end else begin
                m_k++;
            end
        end else if (req) begin
            m_active = 1'b1;
            m_k      = 1;
            m_a      = req_addr;
            m_sz     = req_acc_sz;
            m_we     = req_we;
            m_wd     = req_wdata;
            m_L      = 2 + int'(m_sz) + int'(!m_we);
            a1       = m_a + 16'd1;
            if (m_we) begin
                if (m_sz) begin
                    ref_mem[m_a] = m_wd[15:8];
                    ref_mem[a1]  = m_wd[7:0];
                end else begin
                    ref_mem[m_a] = m_wd[7:0];
                end
            end else begin
                m_exp_rd = m_sz ? {ref_mem[m_a], ref_mem[a1]} : {8'h00, ref_mem[m_a]};
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic        exp_en;
        logic [15:0] ea;
        if (reset) begin
            if (m_active) begin
                check("busy", busy, 1);
                check("ready", ready, m_k == m_L);
                exp_en = (m_k <= 1 + int'(m_sz));
                check("mem_en", mem_en, exp_en);
                if (exp_en) begin
                    ea = m_a + 16'(m_k - 1);
                    check("mem_we", mem_we, m_we);
                    check("mem_addr", mem_addr, ea);
                    check("mem_wdata", mem_wdata, (m_k == 1 && m_sz) ? m_wd[15:8] : m_wd[7:0]);
                end else begin
                    check("mem_we_off", mem_we, 0);
                end
                if (m_k == m_L) check("rdata_done", rdata, m_we ? m_rd : m_exp_rd);
            end else begin
                check("idle_busy", busy, 0);
                check("idle_ready", ready, 0);
                check("idle_mem_en", mem_en, 0);
                check("idle_mem_we", mem_we, 0);
                check("idle_rdata", rdata, m_rd);
            end
        end
    end

    int          t_lat;
    int          t_n;
    logic [15:0] t_addr [0:3];
    logic [7:0]  t_wd   [0:3];

    task automatic rec();
        if (mem_en) begin
            if (t_n < 4) begin
                t_addr[t_n] = mem_addr;
                t_wd[t_n]   = mem_wdata;
            end
            t_n++;
        end
    endtask

    // One request from idle; measures latency and records the byte accesses.
    task automatic txn(input logic [15:0] a, input logic sz, input logic we, input logic [15:0] wd);
        @(negedge clk);
        req = 1'b1; req_addr = a; req_acc_sz = sz; req_we = we; req_wdata = wd;
        @(negedge clk);
        req   = 1'b0;
        t_lat = 1;
        t_n   = 0;
        rec();
        while (!ready && t_lat < 12) begin
            @(negedge clk);
            t_lat++;
            rec();
        end
        check("ready_seen", ready, 1);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; req_addr = 16'h0; req_acc_sz = 1'b0;
        req_we = 1'b0; req_wdata = 16'h0;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] v;
            v          = 8'($urandom);
            ram[i]     = v;
            ref_mem[i] = v;
        end
        set_byte(16'h0010, 8'hA5);
        set_byte(16'hFFFF, 8'h12);
        set_byte(16'h0000, 8'h34);
        set_byte(16'h0201, 8'h5A);
        set_byte(16'h0040, 8'hFF);
        set_byte(16'h0041, 8'hFF);
        set_byte(16'h0042, 8'h80);

        repeat (3) @(negedge clk);
        check("por_rdata", rdata, 0);
        check("por_ready", ready, 0);
        check("por_busy", busy, 0);
        check("por_mem_en", mem_en, 0);
        check("por_mem_we", mem_we, 0);
        check("por_mem_addr", mem_addr, 0);
        check("por_mem_wdata", mem_wdata, 0);
        #1 reset = 1'b1;

        // Reset during the ACC1 cycle of a 16-bit read.
        @(negedge clk);
        req = 1'b1; req_addr = 16'h0040; req_acc_sz = 1'b1; req_we = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("acc1_mem_en", mem_en, 1);
        check("acc1_mem_addr", mem_addr, 16'h0041);
        #2 reset = 1'b0;
        #1;
        check("arst_rdata", rdata, 0);
        check("arst_ready", ready, 0);
        check("arst_busy", busy, 0);
        check("arst_mem_en", mem_en, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        #1 reset = 1'b1;

        txn(16'h0010, 1'b0, 1'b0, 16'h0000);
        check("rd8_lat", t_lat, 3);
        check("rd8_rdata", rdata, 16'h00A5);

        txn(16'h0100, 1'b1, 1'b1, 16'hBEEF);
        check("wr16_lat", t_lat, 3);
        check("wr16_n", t_n, 2);
        check("wr16_a0", t_addr[0], 16'h0100);
        check("wr16_d0", t_wd[0], 8'hBE);
        check("wr16_a1", t_addr[1], 16'h0101);
        check("wr16_d1", t_wd[1], 8'hEF);

        txn(16'h0100, 1'b1, 1'b0, 16'h0000);
        check("rd16_lat", t_lat, 4);
        check("rd16_rdata", rdata, 16'hBEEF);

        txn(16'hFFFF, 1'b1, 1'b0, 16'h0000);
        check("wrap_a1", t_addr[1], 16'h0000);
        check("wrap_rdata", rdata, 16'h1234);

        txn(16'h0200, 1'b0, 1'b1, 16'h7733);
        check("wr8_lat", t_lat, 2);
        check("wr8_n", t_n, 1);
        check("wr8_d0", t_wd[0], 8'h33);
        check("wr8_ram201", ram[16'h0201], 8'h5A);
        check("wr8_rdata", rdata, 16'h1234);

        txn(16'h0040, 1'b1, 1'b0, 16'h0000);
        check("zx_rd16", rdata, 16'hFFFF);
        txn(16'h0042, 1'b0, 1'b0, 16'h0000);
        check("zx_rd8", rdata, 16'h0080);

        // req held high with wandering address during a 16-bit read.
        @(negedge clk);
        req = 1'b1; req_addr = 16'h0300; req_acc_sz = 1'b1; req_we = 1'b0;
        t_n = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            rec();
            check("hold_busy", busy, 1);
            req_addr = 16'h0300 + 16'(i * 16);
        end
        check("hold_ready", ready, 1);
        check("hold_n", t_n, 2);
        check("hold_a0", t_addr[0], 16'h0300);
        check("hold_a1", t_addr[1], 16'h0301);
        @(negedge clk);
        check("hold_idle", busy, 0);
        @(negedge clk);
        check("hold_restart", busy, 1);
        check("hold_new_addr", mem_addr, 16'h0340);
        req = 1'b0;
        repeat (6) @(negedge clk);

        // Random phase: inputs change every cycle, busy or not.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            req        = ($urandom_range(0, 2) == 0);
            req_addr   = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                     : 16'($urandom_range(0, 15));
            req_acc_sz = 1'($urandom);
            req_we     = 1'($urandom);
            req_wdata  = 16'($urandom);
        end
        @(negedge clk);
        req = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
